// File: rtl/bcd_converter_if.sv
// -----------------------------------------------------------------------------
// bcd_converter_if
// Groups the CPU-side request signals and the display-side result signals of
// the binary-to-BCD converter.
//   i_BUS      : unsigned binary operand (DATA_WIDTH bits)
//   i_START    : conversion request
//   o_BUSY     : conversion in progress
//   o_DONE     : one-cycle result strobe
//   o_BCD      : six packed BCD digits, [3:0] = ones digit
//   o_OVERFLOW : last operand exceeded 999999
// Modports: master = requester / observer, slave = converter.
// -----------------------------------------------------------------------------
interface bcd_converter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_BUS;
    logic                  i_START;
    logic                  o_BUSY;
    logic                  o_DONE;
    logic [23:0]           o_BCD;
    logic                  o_OVERFLOW;

    modport master (
        output i_BUS,
        output i_START,
        input  o_BUSY,
        input  o_DONE,
        input  o_BCD,
        input  o_OVERFLOW
    );

    modport slave (
        input  i_BUS,
        input  i_START,
        output o_BUSY,
        output o_DONE,
        output o_BCD,
        output o_OVERFLOW
    );
endinterface

// File: rtl/bcd_converter.sv
// -----------------------------------------------------------------------------
// bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock,
// 20 iterations per conversion. Operands above 999999 saturate to 999999
// and raise the overflow flag.
// Ports:
//   i_SYS_CLOCK : system clock, rising edge
//   i_CLEAR_n   : asynchronous active-low reset
//   bus         : bcd_converter_if.slave (i_BUS, i_START, o_BUSY, o_DONE,
//                 o_BCD, o_OVERFLOW)
// -----------------------------------------------------------------------------
module bcd_converter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_SYS_CLOCK,
    input  logic                  i_CLEAR_n,
    bcd_converter_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [23:0] scratch_q,   scratch_d;
    logic [19:0] shift_q,     shift_d;
    logic        ovf_flag_q,  ovf_flag_d;
    logic [23:0] bcd_q,       bcd_d;
    logic        ovf_q,       ovf_d;

    logic [DATA_WIDTH-1:0] bus_s;
    logic [31:0]           operand_s;
    logic [23:0]           adj_s;

    // Add 3 to every nibble that is 5 or more, all six in parallel
    function automatic logic [23:0] dabble_adjust(input logic [23:0] s);
        logic [23:0] r;
        logic [3:0]  nib;
        r = 24'd0;
        for (int i = 0; i < 6; i++) begin
            nib = s[4*i +: 4];
            if (nib >= 4'd5) begin
                r[4*i +: 4] = nib + 4'd3;
            end else begin
                r[4*i +: 4] = nib;
            end
        end
        return r;
    endfunction

    assign bus_s     = bus.i_BUS;
    assign operand_s = 32'(bus_s);
    assign adj_s     = dabble_adjust(scratch_q);

    // Next-state and datapath decode for the IDLE/SHIFT/DONE sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        shift_d    = shift_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_START) begin
                    scratch_d  = 24'd0;
                    shift_d    = operand_s[19:0];
                    ovf_flag_d = (operand_s > 32'd999999);
                    cnt_d      = 5'd0;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Scratch bit 23 is dropped: in-range values never reach it,
                // and out-of-range values are replaced by the saturated result.
                {scratch_d, shift_d} = {adj_s[22:0], shift_q, 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd19) begin
                    if (ovf_flag_q) begin
                        bcd_d = 24'h999999;
                    end else begin
                        bcd_d = {adj_s[22:0], shift_q[19]};
                    end
                    ovf_d   = ovf_flag_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            scratch_q  <= 24'd0;
            shift_q    <= 20'd0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= 24'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            shift_q    <= shift_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.o_BUSY     = (state_q == ST_SHIFT);
    assign bus.o_DONE     = (state_q == ST_DONE);
    assign bus.o_BCD      = bcd_q;
    assign bus.o_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter
// Self-checking bench for bcd_converter: a 24-bit and an 8-bit instance share
// clock and reset; results are compared with an arithmetic decimal model.
// -----------------------------------------------------------------------------
module tb_bcd_converter;

    logic clk;
    logic rst_n;

    bcd_converter_if #(.DATA_WIDTH(24)) io24 ();
    bcd_converter_if #(.DATA_WIDTH(8))  io8  ();

    bcd_converter #(.DATA_WIDTH(24)) dut24 (
        .i_SYS_CLOCK (clk),
        .i_CLEAR_n   (rst_n),
        .bus         (io24.slave)
    );

    bcd_converter #(.DATA_WIDTH(8)) dut8 (
        .i_SYS_CLOCK (clk),
        .i_CLEAR_n   (rst_n),
        .bus         (io8.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: saturate above 999999, else peel digits with / and %
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        r = 24'd0;
        if (v > 32'd999999) begin
            r = 24'h999999;
        end else begin
            x = v;
            for (int i = 0; i < 6; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [23:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // One full conversion on both instances with latency and result checks
    task automatic run_conv(input logic [23:0] v);
        int cyc;
        int busy_n;
        logic [23:0] v8;
        v8 = {16'd0, v[7:0]};
        @(negedge clk);
        io24.i_BUS = v; io8.i_BUS = v[7:0];
        io24.i_START = 1'b1; io8.i_START = 1'b1;
        @(negedge clk);
        io24.i_START = 1'b0; io8.i_START = 1'b0;
        cyc = 0; busy_n = 0;
        while (!io24.o_DONE && cyc < 40) begin
            if (io24.o_BUSY) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", cyc, 20);
        check_eq("busy_cycles", busy_n, 20);
        check_eq("busy_at_done", io24.o_BUSY, 1'b0);
        check_eq("bcd24", io24.o_BCD, ref_bcd(v));
        check_eq("ovf24", io24.o_OVERFLOW, (v > 24'd999999));
        check_eq("digits24", digits_ok(io24.o_BCD), 1'b1);
        check_eq("done8", io8.o_DONE, 1'b1);
        check_eq("bcd8", io8.o_BCD, ref_bcd(v8));
        check_eq("ovf8", io8.o_OVERFLOW, 1'b0);
        @(negedge clk);
        check_eq("done_drop24", io24.o_DONE, 1'b0);
        check_eq("done_drop8", io8.o_DONE, 1'b0);
        check_eq("bcd_held", io24.o_BCD, ref_bcd(v));
    endtask

    initial begin
        int cyc;
        int dones;
        logic [23:0] rv;

        rst_n = 1'b0;
        io24.i_BUS = 24'd0; io24.i_START = 1'b0;
        io8.i_BUS  = 8'd0;  io8.i_START  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", io24.o_BUSY, 1'b0);
        check_eq("rst_done", io24.o_DONE, 1'b0);
        check_eq("rst_bcd", io24.o_BCD, 24'd0);
        check_eq("rst_ovf", io24.o_OVERFLOW, 1'b0);
        rst_n = 1'b1;

        // Basic, boundaries and narrow-bus cases
        run_conv(24'd123456);
        run_conv(24'd0);
        run_conv(24'd999999);
        run_conv(24'd1000000);
        run_conv(24'hFFFFFF);
        run_conv(24'h0000FF);
        run_conv(24'h00000A);

        // Ignored starts and bus change mid-conversion
        @(negedge clk);
        io24.i_BUS = 24'd42; io24.i_START = 1'b1;
        @(negedge clk);
        io24.i_START = 1'b0;
        cyc = 0;
        while (!io24.o_DONE && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                io24.i_BUS = 24'd77; io24.i_START = 1'b1;
            end else begin
                io24.i_START = 1'b0;
            end
        end
        check_eq("ign_latency", cyc, 20);
        check_eq("ign_bcd", io24.o_BCD, 24'h000042);
        check_eq("ign_ovf", io24.o_OVERFLOW, 1'b0);
        io24.i_START = 1'b1;                 // sampled while in DONE
        @(negedge clk);
        check_eq("ign_done_once", io24.o_DONE, 1'b0);
        check_eq("ign_no_restart", io24.o_BUSY, 1'b0);
        @(negedge clk);                      // edge k+22 accepts
        check_eq("restart_k22", io24.o_BUSY, 1'b1);
        io24.i_START = 1'b0;
        cyc = 0;
        while (!io24.o_DONE && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("restart_latency", cyc, 20);
        check_eq("restart_bcd", io24.o_BCD, 24'h000077);

        // Reset mid-conversion
        @(negedge clk);
        io24.i_BUS = 24'd999999; io24.i_START = 1'b1;
        @(negedge clk);
        io24.i_START = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("pre_rst_busy", io24.o_BUSY, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", io24.o_BUSY, 1'b0);
        check_eq("arst_done", io24.o_DONE, 1'b0);
        check_eq("arst_bcd", io24.o_BCD, 24'd0);
        check_eq("arst_ovf", io24.o_OVERFLOW, 1'b0);
        #2;
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (io24.o_DONE || io24.o_BUSY) dones++;
        end
        check_eq("no_done_after_rst", dones, 0);
        run_conv(24'd5);

        // Randomised sweep, biased so both in-range and overflow are common
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                rv = 24'($urandom_range(0, 999999));
            end else begin
                rv = 24'($urandom_range(0, 24'hFFFFFF));
            end
            run_conv(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
